// File: rtl/ucode_fetch_queue_if.sv
// Bundle of the control, SRAM read and instruction-delivery signals of ucode_fetch_queue.
// master: the surrounding environment (controller, SRAM, consumer); slave: the fetch queue.
interface ucode_fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           length;
  logic                  sram_rd_en;
  logic [ADDR_WIDTH-1:0] sram_rd_addr;
  logic [127:0]          sram_rd_data;
  logic                  instr_valid;
  logic [127:0]          instr_data;
  logic [15:0]           instr_pc;
  logic                  instr_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, flush, base_addr, length, sram_rd_data, instr_ready,
    input  sram_rd_en, sram_rd_addr, instr_valid, instr_data, instr_pc, busy, done
  );

  modport slave (
    input  start, flush, base_addr, length, sram_rd_data, instr_ready,
    output sram_rd_en, sram_rd_addr, instr_valid, instr_data, instr_pc, busy, done
  );
endinterface

// File: rtl/ucode_fetch_queue.sv
// Microcode fetch queue: streams `length` words from SRAM into a small FIFO for the sequencer.
// Define UCODE_FETCH_END_STOP_EN to stop fetching at the first word whose low byte is 8'hFF.
module ucode_fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ucode_fetch_queue_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           len_q;
  logic [15:0]           fetch_ptr_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [15:0]           rd_idx_q;
  logic                  pend_q;
  logic [15:0]           pend_idx_q;
  logic                  done_q;

  logic [CntW-1:0]       occ_q, occ_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [127:0]          mem_data_q [DEPTH];
  logic [15:0]           mem_pc_q   [DEPTH];

  logic                  pop, push, stop_hit, issue, pend_d, drain_done;
  logic [SumW-1:0]       credit_sum;

  assign pop  = (occ_q != '0) && bus.instr_ready;
  assign push = pend_q && !bus.flush;

`ifdef UCODE_FETCH_END_STOP_EN
  assign stop_hit = push && (bus.sram_rd_data[7:0] == 8'hFF);
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    // Words already owned by the queue; a pop this cycle frees a slot before the new read lands.
    credit_sum = SumW'(occ_q) + SumW'(rd_en_q) + SumW'(pend_q) - SumW'(pop);
    issue      = (state_q == StRun) && !bus.flush && !stop_hit &&
                 (fetch_ptr_q < len_q) && (credit_sum < SumW'(DEPTH));

    occ_d = occ_q;
    if (push) occ_d = occ_d + CntW'(1);
    if (pop)  occ_d = occ_d - CntW'(1);
    if (bus.flush) occ_d = '0;

    pend_d     = rd_en_q && !bus.flush && !stop_hit;
    drain_done = (state_q == StDrain) && (occ_d == '0) && !pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      fetch_ptr_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_idx_q    <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_en_q    <= issue;
      pend_q     <= pend_d;
      pend_idx_q <= rd_idx_q;
      if (issue) begin
        rd_addr_q   <= base_q + ADDR_WIDTH'(fetch_ptr_q);
        rd_idx_q    <= fetch_ptr_q;
        fetch_ptr_q <= fetch_ptr_q + 16'd1;
      end
      if (bus.flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              base_q      <= bus.base_addr;
              len_q       <= bus.length;
              fetch_ptr_q <= '0;
              if (bus.length == 16'd0) done_q  <= 1'b1;
              else                     state_q <= StRun;
            end
          end
          StRun: begin
            if (stop_hit || (fetch_ptr_q == len_q)) state_q <= StDrain;
          end
          StDrain: begin
            if (drain_done) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else if (bus.flush) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) begin
        mem_data_q[wr_ptr_q] <= bus.sram_rd_data;
        mem_pc_q[wr_ptr_q]   <= pend_idx_q;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign bus.sram_rd_en   = rd_en_q;
  assign bus.sram_rd_addr = rd_addr_q;
  assign bus.instr_valid  = (occ_q != '0);
  assign bus.instr_data   = mem_data_q[rd_ptr_q];
  assign bus.instr_pc     = mem_pc_q[rd_ptr_q];
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ucode_fetch_queue.sv
// Directed bench for ucode_fetch_queue: SRAM model with one-cycle read latency, read/pop logs.
module tb_ucode_fetch_queue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] stop_addr;

  logic [15:0]  rd_log[$];
  logic [15:0]  pop_pc[$];
  logic [127:0] pop_dat[$];

  ucode_fetch_queue_if #(.ADDR_WIDTH(16)) bus ();

  ucode_fetch_queue #(.ADDR_WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input logic [15:0] a);
    logic [7:0] lo;
    lo = (a == stop_addr) ? 8'hFF : {a[6:0], 1'b0};
    return {a, ~a, a ^ 16'hA5A5, 16'h1234, a, 16'hBEEF, a + 16'd7, 8'h3C, lo};
  endfunction

  always @(posedge clk) begin
    bus.sram_rd_data <= bus.sram_rd_en ? word_of(bus.sram_rd_addr) : '0;
    if (rst_n && bus.sram_rd_en) rd_log.push_back(bus.sram_rd_addr);
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      pop_pc.push_back(bus.instr_pc);
      pop_dat.push_back(bus.instr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    pop_pc.delete();
    pop_dat.delete();
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic kick(input logic [15:0] base, input logic [15:0] len);
    bus.base_addr = base;
    bus.length    = len;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [15:0] wrap_exp[4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    n_cmp = 0;
    n_err = 0;
    stop_addr       = 16'hDEAD;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.flush       = 1'b0;
    bus.base_addr   = '0;
    bus.length      = '0;
    bus.instr_ready = 1'b0;

    #3;
    chk("rst_rd_en",   bus.sram_rd_en,   0);
    chk("rst_rd_addr", bus.sram_rd_addr, 0);
    chk("rst_valid",   bus.instr_valid,  0);
    chk("rst_data",    bus.instr_data,   0);
    chk("rst_pc",      bus.instr_pc,     0);
    chk("rst_busy",    bus.busy,         0);
    chk("rst_done",    bus.done,         0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic stream, cycle by cycle
    clear_logs();
    bus.instr_ready = 1'b1;
    kick(16'h0100, 16'd3);
    chk("t1_busy", bus.busy, 1);
    chk("t1_rd_en_n", bus.sram_rd_en, 0);
    tick();
    chk("t1_rd_en_n1", bus.sram_rd_en, 1);
    chk("t1_addr0", bus.sram_rd_addr, 16'h0100);
    tick();
    chk("t1_addr1", bus.sram_rd_addr, 16'h0101);
    chk("t1_valid_n2", bus.instr_valid, 0);
    tick();
    chk("t1_addr2", bus.sram_rd_addr, 16'h0102);
    chk("t1_valid_n3", bus.instr_valid, 1);
    chk("t1_pc0", bus.instr_pc, 0);
    chk("t1_data0", bus.instr_data, word_of(16'h0100));
    tick();
    chk("t1_rd_en_off", bus.sram_rd_en, 0);
    chk("t1_pc1", bus.instr_pc, 1);
    tick();
    chk("t1_pc2", bus.instr_pc, 2);
    chk("t1_done_early", bus.done, 0);
    tick();
    chk("t1_valid_end", bus.instr_valid, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_busy_end", bus.busy, 0);
    tick();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_nreads", rd_log.size(), 3);

    // Address wrap-around
    clear_logs();
    kick(16'hFFFE, 16'd4);
    wait_done(40, seen);
    chk("t2_done_seen", seen, 1);
    chk("t2_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_addr", rd_log[i], wrap_exp[i]);
    chk("t2_npops", pop_pc.size(), 4);

    // Backpressure: queue fills, head holds
    clear_logs();
    bus.instr_ready = 1'b0;
    kick(16'h0200, 16'd8);
    repeat (5) tick();
    chk("t3_pc_mid", bus.instr_pc, 0);
    repeat (5) tick();
    chk("t3_nreads", rd_log.size(), 4);
    chk("t3_valid", bus.instr_valid, 1);
    chk("t3_pc_hold", bus.instr_pc, 0);
    chk("t3_data_hold", bus.instr_data, word_of(16'h0200));
    bus.instr_ready = 1'b1;
    wait_done(60, seen);
    chk("t3_done_seen", seen, 1);
    chk("t3_npops", pop_pc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_pc", pop_pc[i], 16'(i));
      chk("t3_pop_data", pop_dat[i], word_of(16'h0200 + 16'(i)));
    end

    // Flush with two words queued and one in flight
    clear_logs();
    bus.instr_ready = 1'b0;
    kick(16'h0300, 16'd3);
    repeat (3) tick();
    chk("t4_valid_pre", bus.instr_valid, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t4_valid", bus.instr_valid, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_rd_en", bus.sram_rd_en, 0);
    tick();
    chk("t4_valid_late", bus.instr_valid, 0);
    chk("t4_done_late", bus.done, 0);
    clear_logs();
    bus.instr_ready = 1'b1;
    kick(16'h0300, 16'd3);
    wait_done(40, seen);
    chk("t4_redo_done", seen, 1);
    chk("t4_redo_npops", pop_pc.size(), 3);
    chk("t4_redo_pc0", pop_pc[0], 0);
    chk("t4_redo_pc2", pop_pc[2], 2);

    // Zero length, then start while busy
    clear_logs();
    kick(16'h0000, 16'd0);
    chk("t5_zero_done", bus.done, 1);
    chk("t5_zero_busy", bus.busy, 0);
    tick();
    chk("t5_zero_pulse", bus.done, 0);
    chk("t5_zero_reads", rd_log.size(), 0);
    kick(16'h0400, 16'd8);
    tick();
    tick();
    kick(16'h0500, 16'd2);
    wait_done(60, seen);
    chk("t5_run_done", seen, 1);
    chk("t5_run_npops", pop_pc.size(), 8);
    chk("t5_run_pc7", pop_pc[7], 7);
    chk("t5_run_nreads", rd_log.size(), 8);
    chk("t5_run_addr7", rd_log[7], 16'h0407);
    tick();
    chk("t5_idle_rd_en", bus.sram_rd_en, 0);

    // End-of-program marker in word 2
    clear_logs();
    stop_addr = 16'h0602;
    kick(16'h0600, 16'd10);
    wait_done(80, seen);
    chk("t6_done", seen, 1);
    chk("t6_data2", pop_dat[2], word_of(16'h0602));
`ifdef UCODE_FETCH_END_STOP_EN
    chk("t6_npops", pop_pc.size(), 3);
    chk("t6_last_pc", pop_pc[2], 2);
`else
    chk("t6_npops", pop_pc.size(), 10);
    chk("t6_last_pc", pop_pc[9], 9);
`endif
    stop_addr = 16'hDEAD;

    // Reset in the middle of a fetch
    clear_logs();
    bus.instr_ready = 1'b0;
    kick(16'h0700, 16'd4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", bus.instr_valid, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_rd_en", bus.sram_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t7_after_valid", bus.instr_valid, 0);
    chk("t7_after_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ucode_fetch_queue.md
UCODE_FETCH_QUEUE -- requirements
Module: ucode_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: SRAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin fetch; sampled in IDLE only.
REQ-006 SHALL have port flush  input  1  abort; discards all queued and in-flight words.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first instruction word address; latched on start.
REQ-008 SHALL have port length  input  16  instruction count; latched on start.
REQ-009 SHALL have port sram_rd_en  output  1  read strobe; registered.
REQ-010 SHALL have port sram_rd_addr  output  ADDR_WIDTH  read address; registered.
REQ-011 SHALL have port sram_rd_data  input  128  read data, valid exactly one cycle after sram_rd_en.
REQ-012 SHALL have port instr_valid  output  1  queue head valid (queue not empty).
REQ-013 SHALL have port instr_data  output  128  head instruction word.
REQ-014 SHALL have port instr_pc  output  16  head word index relative to base_addr.
REQ-015 SHALL have port instr_ready  input  1  consumer accepts head; pop when instr_valid and instr_ready.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when every fetched word has been popped.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 IDLE with start: latch base_addr and length, clear fetch_ptr, go to RUN; if length==0, pulse done the next cycle and stay in IDLE.
REQ-020 RUN: issue a read only when fetch_ptr<length and (occupancy + in-flight)<DEPTH; the queue therefore never overflows.
REQ-021 Each issued read SHALL drive sram_rd_addr=(base_addr+fetch_ptr) mod 2^ADDR_WIDTH, with wrap-around allowed, and then increment fetch_ptr.
REQ-022 Returned data SHALL be written to the queue at the end of the cycle it is valid, tagged with its fetch index.
REQ-023 Latency: start sampled at edge N, sram_rd_en high in cycle N+1, instr_valid high in cycle N+3.
REQ-024 Throughput: with instr_ready held high, the block SHALL deliver one instruction per cycle sustained.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; pop on empty is impossible because instr_valid is low.
REQ-026 When fetch_ptr==length, the block SHALL move from RUN to DRAIN and issue no further reads.
REQ-027 DRAIN: when the queue is empty and no read is in flight, pulse done for one cycle and return to IDLE.
REQ-028 instr_data and instr_pc SHALL be stable while instr_valid is high and instr_ready is low.
REQ-029 flush in any state SHALL, next cycle: empty the queue, deassert sram_rd_en, drop any in-flight return, and enter IDLE with no done pulse.
REQ-030 flush SHALL have priority over start in the same cycle.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 Reset SHALL be asynchronous on rst_n low and set: state=IDLE, queue empty, fetch_ptr=0, sram_rd_en=0, sram_rd_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0, done=0.
REQ-033 Reset mid-fetch SHALL discard any returning SRAM data.

Configuration
REQ-034 When macro UCODE_FETCH_END_STOP_EN is defined, capturing a word with bits[7:0]==8'hFF SHALL enqueue that word, stop further reads, discard any later in-flight return, and enter DRAIN.
REQ-035 When UCODE_FETCH_END_STOP_EN is undefined, the block SHALL fetch exactly length words regardless of content.

Verification
REQ-036 base=0x0100, length=3, instr_ready=1 -> reads 0x0100..0x0102 in consecutive cycles; instr_pc 0,1,2; done one cycle after last pop.
REQ-037 DEPTH=4, length=8, instr_ready=0 for 10 cycles -> exactly 4 reads issued, instr_valid held, head instr_pc=0 stable; releasing ready delivers all 8 in order.
REQ-038 base=0xFFFE, length=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 flush asserted while 2 words are queued and 1 is in flight -> next cycle instr_valid=0, busy=0, no done pulse; a subsequent start refetches from pc 0.
REQ-040 With UCODE_FETCH_END_STOP_EN defined, length=10 and word 2 opcode 0xFF -> pops pc 0,1,2 only, then done; without the macro all 10 are delivered.
REQ-041 length=0 start -> no sram_rd_en, done pulse one cycle later; start during RUN is ignored.
